// File: rtl/game_ctrl_pkg.sv
// Shared encodings for the game supervisor and the LED stage downstream.
// Holds the 2-bit game state and the nine 4-bit direction modes, plus
// the button-to-mode decode used while a game is in progress.
package game_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_START = 2'd0,
      ST_PLAY  = 2'd1,
      ST_LOSE  = 2'd2,
      ST_WIN   = 2'd3
   } game_state_t;

   typedef enum logic [3:0] {
      MODE_NONE      = 4'b0000,
      MODE_UP        = 4'b0010,
      MODE_DOWN      = 4'b1000,
      MODE_LEFT      = 4'b0001,
      MODE_RIGHT     = 4'b0100,
      MODE_LEFTUP    = 4'b0011,
      MODE_LEFTDOWN  = 4'b0101,
      MODE_RIGHTUP   = 4'b0110,
      MODE_RIGHTDOWN = 4'b0111
   } mode_t;

   // Opposing buttons on one axis cancel that axis only.
   function automatic mode_t decode_mode(input logic up, input logic down,
                                         input logic left, input logic right);
      logic  v_up, v_dn, h_l, h_r;
      mode_t m;
      v_up = up & ~down;
      v_dn = down & ~up;
      h_l  = left & ~right;
      h_r  = right & ~left;
      if (v_up)
         m = h_l ? MODE_LEFTUP : (h_r ? MODE_RIGHTUP : MODE_UP);
      else if (v_dn)
         m = h_l ? MODE_LEFTDOWN : (h_r ? MODE_RIGHTDOWN : MODE_DOWN);
      else
         m = h_l ? MODE_LEFT : (h_r ? MODE_RIGHT : MODE_NONE);
      return m;
   endfunction

endpackage

// File: rtl/game_ctrl_onepulse.sv
// onepulse: rising-edge detector for a synchronous level.
//   clk, rst_n : clock, asynchronous active-low reset
//   sig        : input level
//   pulse      : high for the one cycle where sig=1 and the previous sample was 0
// History resets to 1 so a level held through reset produces no pulse.
module onepulse (
   input  logic clk,
   input  logic rst_n,
   input  logic sig,
   output logic pulse
);

   logic hist;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) hist <= 1'b1;
      else        hist <= sig;
   end

   assign pulse = sig & ~hist;

endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: game supervisor feeding the LED controller.
//   clk, rst_n          : clock, asynchronous active-low reset
//   btn_start           : start button level (rising edge starts / aborts hold)
//   btn_up/down/left/right : direction levels, decoded to mode in PLAY
//   hit, collide        : one-cycle playfield event pulses
//   state               : START/PLAY/LOSE/WIN
//   mode                : registered direction code
//   score, time_left    : game score and remaining ticks
//   tick                : one-cycle pulse per game tick
module game_ctrl
   import game_ctrl_pkg::*;
#(
   parameter int unsigned TICK_DIV   = 1_000_000,
   parameter int unsigned TIME_LIMIT = 60,
   parameter int unsigned WIN_SCORE  = 10,
   parameter int unsigned HOLD_TICKS = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_start,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       hit,
   input  logic       collide,
   output logic [1:0] state,
   output logic [3:0] mode,
   output logic [7:0] score,
   output logic [7:0] time_left,
   output logic       tick
);

   localparam int unsigned CW = $clog2(TICK_DIV);
   localparam int unsigned HW = $clog2(HOLD_TICKS + 1);

   game_state_t state_q, state_d;
   mode_t       mode_q, mode_d;
   logic [7:0]  score_q, score_d;
   logic [7:0]  time_q, time_d;
   logic [CW-1:0] cnt_q;
   logic [HW-1:0] hold_q, hold_d;
   logic        tick_q;
   logic        start_pulse;
   logic        wrap;
   logic        clr_cnt;

   onepulse u_start (
      .clk   (clk),
      .rst_n (rst_n),
      .sig   (btn_start),
      .pulse (start_pulse)
   );

   // The game logic acts on the wrap edge itself; the tick output is the
   // registered copy, so it is visible in the same cycle as its effects.
   assign wrap = (cnt_q == CW'(TICK_DIV - 1));

   always_comb begin
      state_d = state_q;
      score_d = score_q;
      time_d  = time_q;
      hold_d  = hold_q;
      clr_cnt = 1'b0;
      unique case (state_q)
         ST_START: begin
            if (start_pulse) begin
               state_d = ST_PLAY;
               clr_cnt = 1'b1;
            end
         end
         ST_PLAY: begin
            if (collide) begin
               state_d = ST_LOSE;
               clr_cnt = 1'b1;
            end else if (hit && (({1'b0, score_q} + 9'd1) >= 9'(WIN_SCORE))) begin
               score_d = score_q + 8'd1;
               state_d = ST_WIN;
               clr_cnt = 1'b1;
            end else begin
               if (hit && (score_q != '1))
                  score_d = score_q + 8'd1;
               if (wrap) begin
                  time_d = time_q - 8'd1;
                  if (time_q <= 8'd1) begin
                     time_d  = '0;
                     state_d = ST_LOSE;
                     clr_cnt = 1'b1;
                  end
               end
            end
         end
         ST_LOSE, ST_WIN: begin
            if (start_pulse)
               state_d = ST_START;
            else if (wrap) begin
               if (hold_q == HW'(HOLD_TICKS - 1))
                  state_d = ST_START;
               else
                  hold_d = hold_q + 1'b1;
            end
         end
         default: state_d = ST_START;
      endcase

      if (state_d != state_q)
         hold_d = '0;
      // Reload on entering (and while in) START so the values are visible immediately.
      if (state_d == ST_START) begin
         score_d = '0;
         time_d  = 8'(TIME_LIMIT);
      end

      mode_d = MODE_NONE;
      if (state_q == ST_PLAY && state_d == ST_PLAY)
         mode_d = decode_mode(btn_up, btn_down, btn_left, btn_right);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_START;
         mode_q  <= MODE_NONE;
         score_q <= '0;
         time_q  <= 8'(TIME_LIMIT);
         hold_q  <= '0;
         cnt_q   <= '0;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         score_q <= score_d;
         time_q  <= time_d;
         hold_q  <= hold_d;
         tick_q  <= wrap;
         if (clr_cnt || wrap) cnt_q <= '0;
         else                 cnt_q <= cnt_q + 1'b1;
      end
   end

   assign state     = state_q;
   assign mode      = mode_q;
   assign score     = score_q;
   assign time_left = time_q;
   assign tick      = tick_q;

endmodule

// File: tb/tb_game_ctrl.sv
module tb_game_ctrl;

   localparam int TD = 4, TL = 5, WS = 3, HT = 2;
   localparam int S_START = 0, S_PLAY = 1, S_LOSE = 2, S_WIN = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic btn_start = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
   logic btn_left = 1'b0, btn_right = 1'b0, hit = 1'b0, collide = 1'b0;
   logic [1:0] state;
   logic [3:0] mode;
   logic [7:0] score, time_left;
   logic       tick;

   game_ctrl #(.TICK_DIV(TD), .TIME_LIMIT(TL), .WIN_SCORE(WS), .HOLD_TICKS(HT)) dut (
      .clk(clk), .rst_n(rst_n), .btn_start(btn_start),
      .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
      .hit(hit), .collide(collide),
      .state(state), .mode(mode), .score(score), .time_left(time_left), .tick(tick)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: game rules in plain integer arithmetic.
   int m_st, m_score, m_time, m_hold, m_since, m_mode, m_tick;
   bit m_prev;
   // Indexed [vertical+1][horizontal+1]; vertical: -1 down, +1 up; horizontal: -1 left, +1 right.
   int mode_lut [3][3] = '{'{5, 8, 7}, '{1, 0, 4}, '{3, 2, 6}};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_st = S_START; m_score = 0; m_time = TL; m_hold = 0;
      m_since = 0; m_mode = 0; m_tick = 0; m_prev = 1'b1;
   endtask

   task automatic check_all();
      chk("state", 32'(state), m_st);
      chk("mode", 32'(mode), m_mode);
      chk("score", 32'(score), m_score);
      chk("time_left", 32'(time_left), m_time);
      chk("tick", 32'(tick), m_tick);
   endtask

   task automatic cyc(input bit st, input bit up, input bit dn, input bit lf,
                      input bit rt, input bit ht, input bit co);
      bit press, tk, restart;
      int nst, v, h;
      btn_start = st; btn_up = up; btn_down = dn; btn_left = lf;
      btn_right = rt; hit = ht; collide = co;
      press   = st && !m_prev;
      m_prev  = st;
      tk      = (m_since == TD - 1);
      nst     = m_st;
      restart = 1'b0;
      case (m_st)
         S_START: if (press) begin nst = S_PLAY; restart = 1'b1; end
         S_PLAY: begin
            if (co) begin
               nst = S_LOSE; restart = 1'b1;
            end else if (ht && m_score + 1 >= WS) begin
               m_score++; nst = S_WIN; restart = 1'b1;
            end else begin
               if (ht && m_score < 255) m_score++;
               if (tk) begin
                  m_time--;
                  if (m_time == 0) begin nst = S_LOSE; restart = 1'b1; end
               end
            end
         end
         default: begin
            if (press) nst = S_START;
            else if (tk) begin
               m_hold++;
               if (m_hold == HT) nst = S_START;
            end
         end
      endcase
      if (nst != m_st) m_hold = 0;
      if (nst == S_START) begin m_score = 0; m_time = TL; end
      v = int'(up) - int'(dn);
      h = int'(rt) - int'(lf);
      m_mode = (m_st == S_PLAY && nst == S_PLAY) ? mode_lut[v + 1][h + 1] : 0;
      m_tick = int'(tk);
      m_since = (restart || tk) ? 0 : m_since + 1;
      m_st = nst;
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_state"}, 32'(state), 0);
      chk({tag, "_mode"}, 32'(mode), 0);
      chk({tag, "_score"}, 32'(score), 0);
      chk({tag, "_time"}, 32'(time_left), TL);
      chk({tag, "_tick"}, 32'(tick), 0);
   endtask

   initial begin
      int n;
      // Reset with start held: no game may begin until a fresh press.
      btn_start = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_reset_vals("reset");
      m_reset();
      rst_n = 1'b1;
      repeat (3) cyc(1, 0, 0, 0, 0, 0, 0);
      chk("held_start_ignored", 32'(state), S_START);
      idle(2);
      cyc(1, 0, 0, 0, 0, 0, 0);
      chk("press_play", 32'(state), S_PLAY);

      // Direction decode.
      cyc(0, 1, 0, 1, 0, 0, 0);
      chk("mode_leftup", 32'(mode), 4'b0011);
      cyc(0, 1, 1, 0, 1, 0, 0);
      chk("mode_right", 32'(mode), 4'b0100);
      cyc(0, 0, 0, 0, 0, 0, 0);
      chk("mode_none", 32'(mode), 4'b0000);

      // Three hits win; WIN is held two ticks.
      cyc(0, 0, 0, 0, 0, 1, 0);
      idle(1);
      cyc(0, 0, 0, 0, 0, 1, 0);
      idle(1);
      cyc(0, 0, 0, 0, 0, 1, 0);
      chk("win_state", 32'(state), S_WIN);
      chk("win_score", 32'(score), 3);
      n = 1;
      for (int i = 0; i < 12; i++) begin
         cyc(0, 0, 0, 0, 0, 0, 0);
         if (state == 2'd3) n++;
      end
      chk("win_len", 32'(n), 8);
      chk("after_win_score", 32'(score), 0);
      chk("after_win_time", 32'(time_left), TL);

      // Time limit expires.
      cyc(1, 0, 0, 0, 0, 0, 0);
      idle(20);
      chk("timeout_state", 32'(state), S_LOSE);
      chk("timeout_time", 32'(time_left), 0);
      idle(10);
      chk("lose_hold_done", 32'(state), S_START);

      // Collide beats hit; start press cuts the hold short.
      cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 0);
      idle(1);
      cyc(0, 0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0, 1, 1);
      chk("collide_state", 32'(state), S_LOSE);
      chk("collide_score", 32'(score), 2);
      cyc(1, 0, 0, 0, 0, 0, 0);
      chk("abort_hold", 32'(state), S_START);

      // Randomized play against the model.
      for (int i = 0; i < 300; i++)
         cyc($urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0);

      // Asynchronous reset in the middle of a game.
      for (int i = 0; i < 40 && m_st != S_START; i++) idle(1);
      chk("back_to_start", 32'(state), S_START);
      cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0, 1, 0);
      cyc(0, 1, 0, 0, 0, 0, 0);
      chk("pre_rst_state", 32'(state), S_PLAY);
      chk("pre_rst_mode", 32'(mode), 4'b0010);
      chk("pre_rst_score", 32'(score), 2);
      rst_n = 1'b0;
      #1;
      check_reset_vals("async_rst");
      m_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
